// File: rtl/apu_pkg.sv
// Shared APU constants: frame-counter register bit positions, mode
// encodings, last step index per mode, and the step strobe decode.
package apu_pkg;

    localparam logic MODE_4STEP = 1'b0;
    localparam logic MODE_5STEP = 1'b1;

    localparam int FC_MODE_BIT    = 7;
    localparam int FC_INHIBIT_BIT = 6;

    localparam logic [2:0] LAST_STEP_4 = 3'd3;
    localparam logic [2:0] LAST_STEP_5 = 3'd4;

    typedef struct packed {
        logic quarter;
        logic half;
        logic irq;
    } fc_strobe_t;

    // Sequencer successor of the step being left.
    function automatic logic [2:0] next_step(input logic mode, input logic [2:0] step);
        logic [2:0] last;
        last = (mode == MODE_5STEP) ? LAST_STEP_5 : LAST_STEP_4;
        return (step >= last) ? 3'd0 : step + 3'd1;
    endfunction

    // Strobes produced when leaving a step. Step 3 in 5-step mode is silent.
    function automatic fc_strobe_t decode_step(input logic mode, input logic [2:0] step);
        fc_strobe_t s;
        s = '0;
        if (mode == MODE_4STEP) begin
            s.quarter = (step <= LAST_STEP_4);
            s.half    = (step == 3'd1) || (step == 3'd3);
            s.irq     = (step == 3'd3);
        end else begin
            s.quarter = (step == 3'd0) || (step == 3'd1) || (step == 3'd2) || (step == 3'd4);
            s.half    = (step == 3'd1) || (step == 3'd4);
            s.irq     = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/apu_frame_divider.sv
// Step event source for the frame counter.
// Default: free-running divider, step_evt on the terminal count.
// APU_FRAME_EXT_TICK_EN: divider removed, step_evt is the rising edge of tick_in.
module apu_frame_divider
    import apu_pkg::*;
#(
    parameter int STEP_CYCLES = 7457,
    parameter int DIV_W       = $clog2(STEP_CYCLES)
) (
    input  logic cpu_clk,
    input  logic rstn,
    input  logic clr,
    input  logic tick_in,
    output logic step_evt
);

`ifdef APU_FRAME_EXT_TICK_EN
    logic tick_d;
    logic unused_clr;

    // Delay flop for rising-edge detect of the external tick.
    always_ff @(posedge cpu_clk) begin
        if (!rstn) tick_d <= 1'b0;
        else       tick_d <= tick_in;
    end

    assign step_evt   = tick_in & ~tick_d;
    // A write only clears the step; the parent discards the coincident edge.
    assign unused_clr = clr;
`else
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_CYCLES - 1);

    logic [DIV_W-1:0] div;
    logic             unused_tick;

    assign step_evt = (div == DIV_LAST);

    // Divider counts 0..STEP_CYCLES-1; a register write restarts it.
    always_ff @(posedge cpu_clk) begin
        if (!rstn || clr)  div <= '0;
        else if (step_evt) div <= '0;
        else               div <= div + 1'b1;
    end

    assign unused_tick = tick_in;
`endif

endmodule

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: mode/inhibit register, step sequencing, registered
// quarter/half frame strobes and the sticky frame IRQ.
// Optional: APU_FRAME_EXT_TICK_EN selects an external step tick (see divider).
module apu_frame_counter
    import apu_pkg::*;
#(
    parameter int STEP_CYCLES = 7457,
    parameter int DIV_W       = $clog2(STEP_CYCLES)
) (
    input  logic       cpu_clk,
    input  logic       rstn,
    input  logic       reg_wr,
    input  logic [7:0] reg_wdata,
    input  logic       irq_clr,
    input  logic       tick_in,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       step_sel,
    output logic [2:0] cur_step
);

    logic       step_evt;
    logic       evt;
    logic       mode;
    logic       inhibit;
    logic [2:0] step;
    logic       wr_mode;
    logic       wr_inh;
    logic       irq_set;
    logic       irq_clear;
    fc_strobe_t dec;

    apu_frame_divider #(
        .STEP_CYCLES (STEP_CYCLES),
        .DIV_W       (DIV_W)
    ) u_div (
        .cpu_clk  (cpu_clk),
        .rstn     (rstn),
        .clr      (reg_wr),
        .tick_in  (tick_in),
        .step_evt (step_evt)
    );

    assign wr_mode = reg_wdata[FC_MODE_BIT];
    assign wr_inh  = reg_wdata[FC_INHIBIT_BIT];

    // A register write takes priority over a coincident step event.
    assign evt       = step_evt & ~reg_wr;
    assign dec       = decode_step(mode, step);
    assign irq_set   = evt & dec.irq & ~inhibit;
    assign irq_clear = irq_clr | (reg_wr & wr_inh);

    // Mode/inhibit register and step index.
    always_ff @(posedge cpu_clk) begin
        if (!rstn) begin
            mode    <= MODE_4STEP;
            inhibit <= 1'b0;
            step    <= 3'd0;
        end else if (reg_wr) begin
            mode    <= wr_mode;
            inhibit <= wr_inh;
            step    <= 3'd0;
        end else if (evt) begin
            step    <= next_step(mode, step);
        end
    end

    // Strobes decode from the step being left; a 5-step write clocks immediately.
    always_ff @(posedge cpu_clk) begin
        if (!rstn) begin
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
        end else if (reg_wr) begin
            quarter_frame <= wr_mode;
            half_frame    <= wr_mode;
        end else begin
            quarter_frame <= evt & dec.quarter;
            half_frame    <= evt & dec.half;
        end
    end

    // Sticky IRQ; a set in the same cycle as a clear wins.
    always_ff @(posedge cpu_clk) begin
        if (!rstn) frame_irq <= 1'b0;
        else       frame_irq <= irq_set | (frame_irq & ~irq_clear);
    end

    assign step_sel = mode;
    assign cur_step = step;

endmodule
